// File: rtl/digitube_scan_ctrl.sv
// Four-digit, active-low 7-segment scan controller. New values wait in a pending register and commit only at a frame wrap.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits 3..1 while they and every higher nibble are zero.
module digitube_scan_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter int DIV_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    output logic [11:0] digi_out,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      act_val_q, act_val_d;
    logic [3:0]       act_dp_q, act_dp_d;
    logic [15:0]      pend_val_q, pend_val_d;
    logic [3:0]       pend_dp_q, pend_dp_d;
    logic             pend_v_q, pend_v_d;
    logic [11:0]      digi_q, digi_d;
    logic             frame_q, frame_d;

    logic             divWrap;
    logic             frameWrap;
    logic             commitNow;
    logic [3:0]       curNibble;
    logic [3:0]       curAnode;
    logic [6:0]       curSeg;
    logic             leadBlank;

    function automatic logic [6:0] hexSeg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // A pending value commits at the frame wrap, or immediately while blanked since nothing can tear.
    // A load on the commit edge lands in pending after the old contents have been taken.
    always_comb begin
        divWrap    = enable && (div_cnt_q == DIV_LAST);
        frameWrap  = divWrap && (idx_q == 2'd3);
        commitNow  = pend_v_q && (frameWrap || !enable);

        div_cnt_d  = '0;
        idx_d      = 2'd0;
        act_val_d  = act_val_q;
        act_dp_d   = act_dp_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_v_d   = pend_v_q;
        frame_d    = frameWrap;

        if (enable) begin
            div_cnt_d = divWrap ? '0 : div_cnt_q + DIV_W'(1);
            idx_d     = divWrap ? idx_q + 2'd1 : idx_q;
        end

        if (commitNow) begin
            act_val_d = pend_val_q;
            act_dp_d  = pend_dp_q;
            pend_v_d  = 1'b0;
        end

        if (load) begin
            pend_val_d = value_in;
            pend_dp_d  = dp_in;
            pend_v_d   = 1'b1;
        end
    end

    // Decoding from next-state makes digit 0 of a fresh commit appear in the same cycle as frame_done.
    always_comb begin
        curNibble = act_val_d[3:0];
        curAnode  = 4'b1110;
        case (idx_d)
            2'd0: begin curNibble = act_val_d[3:0];   curAnode = 4'b1110; end
            2'd1: begin curNibble = act_val_d[7:4];   curAnode = 4'b1101; end
            2'd2: begin curNibble = act_val_d[11:8];  curAnode = 4'b1011; end
            default: begin curNibble = act_val_d[15:12]; curAnode = 4'b0111; end
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        leadBlank = 1'b0;
        case (idx_d)
            2'd1: leadBlank = (act_val_d[15:4] == 12'd0);
            2'd2: leadBlank = (act_val_d[15:8] == 8'd0);
            2'd3: leadBlank = (act_val_d[15:12] == 4'd0);
            default: leadBlank = 1'b0;
        endcase
    end
`else
    assign leadBlank = 1'b0;
`endif

    always_comb begin
        curSeg = leadBlank ? 7'h7F : hexSeg(curNibble);
        digi_d = enable ? {curAnode, ~act_dp_d[idx_d], curSeg} : 12'hFFF;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            idx_q      <= 2'd0;
            act_val_q  <= 16'd0;
            act_dp_q   <= 4'd0;
            pend_val_q <= 16'd0;
            pend_dp_q  <= 4'd0;
            pend_v_q   <= 1'b0;
            digi_q     <= 12'hFFF;
            frame_q    <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            idx_q      <= idx_d;
            act_val_q  <= act_val_d;
            act_dp_q   <= act_dp_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_v_q   <= pend_v_d;
            digi_q     <= digi_d;
            frame_q    <= frame_d;
        end
    end

    assign digi_out   = digi_q;
    assign busy       = pend_v_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_digitube_scan_ctrl.sv
// Bench for digitube_scan_ctrl: per-cycle scoreboard against a behavioural model, a vector table of frames,
// and hand sequences for the commit, disable and reset corner cases.
module tb_digitube_scan_ctrl;

    localparam int SD = 4;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic [11:0] digi_out;
    logic        busy;
    logic        frame_done;

    int assertCount = 0;
    int failCount   = 0;
    int cycleNum    = 0;

    typedef struct {
        logic [11:0] digi;
        logic        busy;
        logic        fd;
    } exp_t;

    typedef struct {
        logic [15:0]      value;
        logic [3:0]       dp;
        logic [3:0][11:0] exp;
    } vec_t;

    exp_t sbQ[$];
    vec_t vecs[6];

    int          m_cnt;
    int          m_idx;
    logic [15:0] m_actV;
    logic [15:0] m_pendV;
    logic [3:0]  m_actD;
    logic [3:0]  m_pendD;
    logic        m_pend;

    digitube_scan_ctrl #(.SCAN_DIV(SD), .DIV_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .digi_out   (digi_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [6:0] segOf(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [11:0] expDigit(input int i, input logic [15:0] v, input logic [3:0] dp);
        logic [3:0]  an;
        logic [15:0] hi;
        logic [6:0]  seg;
        an     = 4'hF;
        an[i]  = 1'b0;
        hi     = v >> (4 * i);
        seg    = segOf(hi[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && hi == 16'd0) seg = 7'h7F;
`endif
        return {an, ~dp[i], seg};
    endfunction

    function automatic vec_t mkVec(input logic [15:0] v, input logic [3:0] dp,
                                   input logic [11:0] e0, input logic [11:0] e1,
                                   input logic [11:0] e2, input logic [11:0] e3);
        vec_t r;
        r.value = v;
        r.dp    = dp;
        r.exp   = {e3, e2, e1, e0};
        return r;
    endfunction

    // Advances the reference model across one clock edge using the inputs currently driven.
    task automatic modelStep(output exp_t e);
        logic fwrap;
        if (!rst_n) begin
            m_cnt = 0; m_idx = 0; m_actV = '0; m_actD = '0;
            m_pendV = '0; m_pendD = '0; m_pend = 1'b0;
            e.digi = 12'hFFF; e.busy = 1'b0; e.fd = 1'b0;
            return;
        end
        fwrap = 1'b0;
        if (!enable) begin
            if (m_pend) begin m_actV = m_pendV; m_actD = m_pendD; m_pend = 1'b0; end
            m_cnt = 0;
            m_idx = 0;
        end else begin
            fwrap = (m_cnt == SD - 1) && (m_idx == 3);
            if (fwrap && m_pend) begin m_actV = m_pendV; m_actD = m_pendD; m_pend = 1'b0; end
            if (m_cnt == SD - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        if (load) begin m_pendV = value_in; m_pendD = dp_in; m_pend = 1'b1; end
        e.fd   = fwrap;
        e.busy = m_pend;
        e.digi = enable ? expDigit(m_idx, m_actV, m_actD) : 12'hFFF;
    endtask

    task automatic checkOutput();
        exp_t e;
        assertCount++;
        if (sbQ.size() == 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard_empty: cycle %0d has no queued expectation", cycleNum);
            return;
        end
        e = sbQ.pop_front();
        if (digi_out !== e.digi || busy !== e.busy || frame_done !== e.fd) begin
            failCount++;
            $display("[TB] FAIL cycle_%0d: got digi=%h busy=%b fd=%b, expected digi=%h busy=%b fd=%b",
                     cycleNum, digi_out, busy, frame_done, e.digi, e.busy, e.fd);
        end
    endtask

    // One clock: queue the model's expectation, take the edge, then compare just after it. load is a one-cycle strobe.
    task automatic applyStimulus();
        exp_t e;
        modelStep(e);
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        load = 1'b0;
        cycleNum++;
        checkOutput();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) applyStimulus();
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic waitFrameDone(input int budget, input bit needIdle, output int waited);
        waited = 0;
        while (!(frame_done === 1'b1 && (!needIdle || busy === 1'b0))) begin
            if (waited >= budget) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL wait_frame_done: no frame_done within %0d cycles", budget);
                return;
            end
            applyStimulus();
            waited++;
        end
    endtask

    task automatic doLoad(input logic [15:0] v, input logic [3:0] dp);
        value_in = v;
        dp_in    = dp;
        load     = 1'b1;
        applyStimulus();
    endtask

    initial begin
        int w;

        vecs[0] = mkVec(16'h1234, 4'b0000, 12'hE99, 12'hDB0, 12'hBA4, 12'h7F9);
        vecs[1] = mkVec(16'hABCD, 4'b0101, 12'hE21, 12'hDC6, 12'hB03, 12'h788);
        vecs[2] = mkVec(16'h5678, 4'b1010, 12'hE80, 12'hD78, 12'hB82, 12'h712);
        vecs[3] = mkVec(16'h90EF, 4'b0000, 12'hE8E, 12'hD86, 12'hBC0, 12'h790);
`ifdef LEADING_ZERO_BLANK_EN
        vecs[4] = mkVec(16'h0042, 4'b0000, 12'hEA4, 12'hD99, 12'hBFF, 12'h7FF);
        vecs[5] = mkVec(16'h0000, 4'b0000, 12'hEC0, 12'hDFF, 12'hBFF, 12'h7FF);
`else
        vecs[4] = mkVec(16'h0042, 4'b0000, 12'hEA4, 12'hD99, 12'hBC0, 12'h7C0);
        vecs[5] = mkVec(16'h0000, 4'b0000, 12'hEC0, 12'hDC0, 12'hBC0, 12'h7C0);
`endif

        rst_n = 1'b0; enable = 1'b0; load = 1'b0; value_in = '0; dp_in = '0;
        m_cnt = 0; m_idx = 0; m_actV = '0; m_actD = '0; m_pendV = '0; m_pendD = '0; m_pend = 1'b0;
        ticks(2);
        checkValue("reset_digi", digi_out, 12'hFFF);
        checkValue("reset_busy", busy, 0);
        checkValue("reset_fd", frame_done, 0);

        rst_n = 1'b1; enable = 1'b1;
        applyStimulus();
        checkValue("first_enabled_digi", digi_out, 12'hEC0);

        for (int i = 0; i < 6; i++) begin
            doLoad(vecs[i].value, vecs[i].dp);
            waitFrameDone(3 * 4 * SD, 1, w);
            for (int d = 0; d < 4; d++) begin
                checkValue($sformatf("vec%0d_digit%0d", i, d), digi_out, vecs[i].exp[d]);
                ticks(SD);
            end
        end

        waitFrameDone(64, 0, w);
        applyStimulus();
        waitFrameDone(64, 0, w);
        checkValue("frame_period", w + 1, 4 * SD);

        // Mid-frame load: digits 2 and 3 keep the old value until the wrap.
        doLoad(16'h1234, 4'b0000);
        waitFrameDone(64, 1, w);
        ticks(SD + 1);
        doLoad(16'h00FF, 4'b0000);
        ticks(2);
        checkValue("midload_digit2_old", digi_out, 12'hBA4);
        checkValue("midload_busy", busy, 1);
        ticks(SD);
        checkValue("midload_digit3_old", digi_out, 12'h7F9);
        waitFrameDone(64, 1, w);
        checkValue("midload_commit_digi", digi_out, 12'hE8E);
        checkValue("midload_commit_busy", busy, 0);

        // Two loads in one frame: the last one wins.
        ticks(2);
        doLoad(16'h1111, 4'b0000);
        applyStimulus();
        doLoad(16'h2222, 4'b0000);
        waitFrameDone(64, 1, w);
        checkValue("lastload_digit0", digi_out, 12'hEA4);
        ticks(SD);
        checkValue("lastload_digit1", digi_out, 12'hDA4);
        waitFrameDone(64, 0, w);

        // Load on the exact wrap edge defers the commit by a whole frame.
        ticks(4 * SD - 1);
        doLoad(16'h3333, 4'b0000);
        checkValue("wrapload_fd", frame_done, 1);
        checkValue("wrapload_busy", busy, 1);
        checkValue("wrapload_digi_old", digi_out, 12'hEA4);
        waitFrameDone(64, 1, w);
        checkValue("wrapload_delay", w, 4 * SD);
        checkValue("wrapload_commit_digi", digi_out, 12'hEB0);

        // Disable mid-frame, load while blanked, then re-enable.
        ticks(5);
        enable = 1'b0;
        applyStimulus();
        checkValue("disable_digi", digi_out, 12'hFFF);
        checkValue("disable_fd", frame_done, 0);
        doLoad(16'h4444, 4'b0000);
        checkValue("disabled_load_busy", busy, 1);
        applyStimulus();
        checkValue("disabled_commit_busy", busy, 0);
        ticks(20);
        enable = 1'b1;
        applyStimulus();
        checkValue("reenable_digit0", digi_out, 12'hE99);

        // Reset mid-frame with a value still pending.
        ticks(6);
        doLoad(16'h5555, 4'b0000);
        checkValue("prereset_busy", busy, 1);
        applyStimulus();
        rst_n = 1'b0;
        applyStimulus();
        checkValue("midreset_digi", digi_out, 12'hFFF);
        checkValue("midreset_busy", busy, 0);
        checkValue("midreset_fd", frame_done, 0);
        rst_n = 1'b1;
        applyStimulus();
        checkValue("postreset_digi", digi_out, 12'hEC0);
        waitFrameDone(64, 0, w);
        checkValue("postreset_frame_digi", digi_out, 12'hEC0);
        ticks(SD);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
